// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin values
// and the one-hot coin encoding ({quarter, dime, nickel}).
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Coin values in nickel units.
    localparam int VAL_Q = 5;
    localparam int VAL_D = 2;
    localparam int VAL_N = 1;

    typedef enum logic [2:0] {
        COIN_NONE = 3'b000,
        COIN_N    = 3'b001,
        COIN_D    = 3'b010,
        COIN_Q    = 3'b100
    } coin_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Request/eject bundle between a vending controller (master) and the change
// dispenser (slave).
//
// Handshake: a request transfers on a rising clk edge where change_valid and
// change_ready are both 1; change_amt is only meaningful in that cycle. The
// dispenser never queues a request, so change_valid while change_ready is 0 is
// dropped. Each disp_* stays high until coin_ack is sampled high with it.
interface change_dispenser_if #(
    parameter int AMT_W = 4
);
    logic             change_valid;
    logic [AMT_W-1:0] change_amt;
    logic             change_ready;
    logic             disp_Q;
    logic             disp_D;
    logic             disp_N;
    logic             coin_ack;
    logic             done;
    logic             short;

    modport master (
        output change_valid, change_amt, coin_ack,
        input  change_ready, disp_Q, disp_D, disp_N, done, short
    );

    modport slave (
        input  change_valid, change_amt, coin_ack,
        output change_ready, disp_Q, disp_D, disp_N, done, short
    );
endinterface

// File: rtl/coin_select.sv
// Greedy coin choice: the largest available coin that does not exceed the
// remaining amount. Purely combinational.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       avail,      // {quarter, dime, nickel} in stock
    output coin_t            coin,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        coin  = COIN_NONE;
        value = '0;
        if (avail[2] && (remaining >= AMT_W'(VAL_Q))) begin
            coin  = COIN_Q;
            value = AMT_W'(VAL_Q);
        end else if (avail[1] && (remaining >= AMT_W'(VAL_D))) begin
            coin  = COIN_D;
            value = AMT_W'(VAL_D);
        end else if (avail[0] && (remaining >= AMT_W'(VAL_N))) begin
            coin  = COIN_N;
            value = AMT_W'(VAL_N);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a nickel-unit amount one coin at a time, greedily.
// Optional coin inventory (with short-pay reporting) is enabled by COIN_INV_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W    = 4,
    parameter int INV_INIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus,
    output state_t              state_dbg
);

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] cur_val;
    logic [AMT_W-1:0] sel_val;
    coin_t            disp_r;
    coin_t            sel_coin;
    logic [2:0]       avail;
    logic             ready_r;
    logic             done_r;

    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .remaining (remaining),
        .avail     (avail),
        .coin      (sel_coin),
        .value     (sel_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            cur_val   <= '0;
            disp_r    <= COIN_NONE;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.change_valid && ready_r) begin
                        remaining <= bus.change_amt;
                        ready_r   <= 1'b0;
                        if (bus.change_amt == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    // No usable coin only happens when stock ran out.
                    if (sel_coin != COIN_NONE) begin
                        disp_r  <= sel_coin;
                        cur_val <= sel_val;
                        state   <= EJECT;
                    end else begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                EJECT: begin
                    if (bus.coin_ack) begin
                        disp_r <= COIN_NONE;
                        if (cur_val <= remaining) begin
                            remaining <= remaining - cur_val;
                        end
                        if (remaining == cur_val) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef COIN_INV_EN
    localparam int INV_W = (INV_INIT > 0) ? $clog2(INV_INIT + 1) : 1;

    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_n;
    logic             short_r;

    assign avail = {inv_q != '0, inv_d != '0, inv_n != '0};

    // Stock only moves on an acknowledged eject; reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= INV_W'(INV_INIT);
            inv_d <= INV_W'(INV_INIT);
            inv_n <= INV_W'(INV_INIT);
        end else if (state == EJECT && bus.coin_ack) begin
            case (disp_r)
                COIN_Q:  if (inv_q != '0) inv_q <= inv_q - INV_W'(1);
                COIN_D:  if (inv_d != '0) inv_d <= inv_d - INV_W'(1);
                COIN_N:  if (inv_n != '0) inv_n <= inv_n - INV_W'(1);
                default: ;
            endcase
        end
    end

    // Raised together with done_r on the SELECT->DONE give-up transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            short_r <= 1'b0;
        end else begin
            short_r <= (state == SELECT) && (sel_coin == COIN_NONE);
        end
    end

    assign bus.short = short_r;
`else
    localparam int unused_inv_init = INV_INIT;

    assign avail     = 3'b111;
    assign bus.short = 1'b0;
`endif

    assign bus.change_ready = ready_r;
    assign bus.done         = done_r;
    assign bus.disp_Q       = disp_r[2];
    assign bus.disp_D       = disp_r[1];
    assign bus.disp_N       = disp_r[0];
    assign state_dbg        = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a vector table of requests with
// hand-computed coin sequences and timing, plus a reset-during-eject sequence.
`timescale 1ns/1ps
module tb_change_dispenser;
    import vend_pkg::*;

`ifdef COIN_INV_EN
    localparam int INV = 1;
`else
    localparam int INV = 8;
`endif

    localparam logic [2:0] CQ = 3'b100;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CN = 3'b001;
    localparam logic [2:0] C0 = 3'b000;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;

    change_dispenser_if #(.AMT_W(4)) bus ();

    change_dispenser #(.AMT_W(4), .INV_INIT(INV)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    typedef struct packed {
        int         amt;
        int         ack_dly;
        bit         ack_hold;
        int         busy_at;
        int         n;
        logic [3:0][2:0] coins;
        bit         short_exp;
        int         done_cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int amt, int dly, bit hold, int busy, int n,
                                logic [2:0] c0, logic [2:0] c1, logic [2:0] c2,
                                logic [2:0] c3, bit sh, int dc);
        vec_t v;
        v.amt = amt; v.ack_dly = dly; v.ack_hold = hold; v.busy_at = busy;
        v.n = n; v.coins = {c3, c2, c1, c0}; v.short_exp = sh; v.done_cyc = dc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.change_valid = 1'b0;
        bus.change_amt = 4'd0;
        bus.coin_ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // ---------------- driver + monitor for one table vector ----------------
    task automatic run_vec(input vec_t v, input int vi);
        int cyc, hi_len, exp_len, seen;
        logic [2:0] disp, prev;
        bit got_done;
        do_reset();
        bus.coin_ack = v.ack_hold;
        for (int k = 0; k < v.n; k++) exp_q.push_back(v.coins[k]);
        exp_len = v.ack_hold ? 1 : v.ack_dly + 1;
        check($sformatf("v%0d_ready_idle", vi), bus.change_ready, 1);
        bus.change_amt = 4'(v.amt);
        bus.change_valid = 1'b1;
        step();
        bus.change_valid = 1'b0;
        cyc = 1; prev = C0; hi_len = 0; seen = 0; got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            disp = {bus.disp_Q, bus.disp_D, bus.disp_N};
            if (disp != C0 && prev == C0) begin
                if (exp_q.size() == 0) check($sformatf("v%0d_extra_coin", vi), disp, C0);
                else check($sformatf("v%0d_coin%0d", vi, seen), disp, exp_q.pop_front());
                if (seen == 0) check($sformatf("v%0d_first_disp_cyc", vi), cyc, 2);
                seen++;
                hi_len = 0;
            end
            if (disp == C0 && prev != C0)
                check($sformatf("v%0d_disp_len", vi), hi_len, exp_len);
            if (disp != C0) hi_len++;
            if (!v.ack_hold) bus.coin_ack = (disp != C0) && (hi_len == v.ack_dly + 1);
            if (v.busy_at == cyc) begin
                bus.change_valid = 1'b1;
                bus.change_amt = 4'd3;
            end else begin
                bus.change_valid = 1'b0;
            end
            if (bus.done) begin
                got_done = 1'b1;
                check($sformatf("v%0d_done_cyc", vi), cyc, v.done_cyc);
                check($sformatf("v%0d_short", vi), bus.short, v.short_exp);
                check($sformatf("v%0d_ready_in_done", vi), bus.change_ready, 0);
                check($sformatf("v%0d_coins_left", vi), exp_q.size(), 0);
            end
            prev = disp;
            if (!got_done) begin
                step();
                cyc++;
            end
        end
        if (!got_done) check($sformatf("v%0d_timeout_done", vi), 0, 1);
        bus.change_valid = 1'b0;
        bus.coin_ack = 1'b0;
        step();
        check($sformatf("v%0d_ready_after", vi), bus.change_ready, 1);
        check($sformatf("v%0d_done_one_cycle", vi), bus.done, 0);
        exp_q.delete();
    endtask

    // ---------------- reset while a dime is being ejected ----------------
    task automatic reset_in_eject();
        int done_seen;
        do_reset();
        bus.change_amt = 4'd4;
        bus.change_valid = 1'b1;
        step();
        bus.change_valid = 1'b0;
        step();
        check("rst_disp_d_high", {bus.disp_Q, bus.disp_D, bus.disp_N}, CD);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_disp_dropped", {bus.disp_Q, bus.disp_D, bus.disp_N}, C0);
        check("rst_no_done", bus.done, 0);
        check("rst_short_low", bus.short, 0);
        check("rst_ready", bus.change_ready, 1);
        check("rst_state_idle", 32'(state_dbg), 32'(IDLE));
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.done || bus.disp_Q || bus.disp_D || bus.disp_N) done_seen++;
        end
        check("rst_quiet_after", done_seen, 0);
        check("rst_ready_after", bus.change_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
`ifdef COIN_INV_EN
        vecs.push_back(mk( 8, 2, 0, 0, 3, CQ, CD, CN, C0, 0, 13));
        vecs.push_back(mk( 0, 0, 0, 0, 0, C0, C0, C0, C0, 0,  1));
        vecs.push_back(mk(11, 1, 0, 0, 3, CQ, CD, CN, C0, 1, 11));
        vecs.push_back(mk( 1, 1, 0, 0, 1, CN, C0, C0, C0, 0,  4));
        vecs.push_back(mk( 4, 0, 0, 0, 2, CD, CN, C0, C0, 1,  6));
        vecs.push_back(mk( 7, 3, 0, 4, 2, CQ, CD, C0, C0, 0, 11));
        vecs.push_back(mk(15, 0, 1, 0, 3, CQ, CD, CN, C0, 1,  8));
`else
        vecs.push_back(mk( 8, 2, 0, 0, 3, CQ, CD, CN, C0, 0, 13));
        vecs.push_back(mk( 0, 0, 0, 0, 0, C0, C0, C0, C0, 0,  1));
        vecs.push_back(mk(15, 0, 1, 0, 3, CQ, CQ, CQ, C0, 0,  7));
        vecs.push_back(mk( 4, 0, 0, 0, 2, CD, CD, C0, C0, 0,  5));
        vecs.push_back(mk( 1, 1, 0, 0, 1, CN, C0, C0, C0, 0,  4));
        vecs.push_back(mk( 7, 3, 0, 4, 2, CQ, CD, C0, C0, 0, 11));
        vecs.push_back(mk( 6, 1, 0, 0, 2, CQ, CN, C0, C0, 0,  7));
        vecs.push_back(mk(14, 1, 0, 0, 4, CQ, CQ, CD, CD, 0, 13));
        vecs.push_back(mk( 9, 0, 0, 1, 3, CQ, CD, CD, C0, 0,  7));
`endif
        reset = 1'b1;
        bus.change_valid = 1'b0;
        bus.change_amt = 4'd0;
        bus.coin_ack = 1'b0;
        step();
        do_reset();
        check("reset_ready", bus.change_ready, 1);
        check("reset_disp", {bus.disp_Q, bus.disp_D, bus.disp_N}, C0);
        check("reset_done", bus.done, 0);
        check("reset_short", bus.short, 0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        reset_in_eject();
        run_vec(vecs[0], 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The module SHALL have the parameter AMT_W, default 4, giving the change amount width in nickel units (0..15 = 0..75 cents).
REQ-002 The module SHALL have the parameter INV_INIT, default 8, giving the reset value of each coin inventory counter (used only with COIN_INV_EN).
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have the port change_valid, input, 1 bit: a change request is presented.
REQ-006 The module SHALL have the port change_amt, input, AMT_W bits: the change owed, in nickels.
REQ-007 The module SHALL have the port change_ready, output, 1 bit: the dispenser can accept a request.
REQ-008 The module SHALL have the ports disp_Q, disp_D and disp_N, outputs, 1 bit each: eject quarter, dime or nickel; at most one is high at a time.
REQ-009 The module SHALL have the port coin_ack, input, 1 bit: the mechanism has ejected the requested coin.
REQ-010 The module SHALL have the port done, output, 1 bit: a one-cycle pulse when a request completes.
REQ-011 The module SHALL have the port short, output, 1 bit: valid with done; the full amount could not be paid.

Function
REQ-012 The dispenser SHALL be an FSM with the states IDLE, SELECT, EJECT and DONE.
REQ-013 In IDLE, change_ready SHALL be 1; in every other state it SHALL be 0.
REQ-014 A request SHALL be accepted when change_valid and change_ready are both 1; change_amt is latched into remaining at that point.
REQ-015 An accepted request with an amount of 0 SHALL go directly to DONE; a nonzero amount SHALL go to SELECT.
REQ-016 SELECT SHALL last one cycle and choose the coin greedily: quarter if remaining>=5, else dime if remaining>=2, else nickel. It then enters EJECT with the chosen disp_* output registered high.
REQ-017 Timing: with acceptance in cycle t, the first disp_* output SHALL be high in cycle t+2.
REQ-018 In EJECT, the disp_* output SHALL stay high until coin_ack is sampled high.
REQ-019 When coin_ack is sampled in EJECT:
- remaining is decremented by 5, 2 or 1 for the coin ejected;
- disp_* goes low in the next cycle;
- the FSM goes to DONE if the new remaining is 0, otherwise to SELECT.
REQ-020 coin_ack outside EJECT SHALL be ignored.
REQ-021 change_valid outside IDLE SHALL be ignored; the request is not queued.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE. change_ready is 0 in DONE, so back-to-back requests are spaced by at least one cycle.
REQ-023 remaining SHALL never underflow; the subtraction is performed only when the coin value is <= remaining.
REQ-024 short SHALL be 0 whenever done is 0.

Reset
REQ-025 When reset is sampled high, the FSM SHALL enter IDLE, with:
- remaining = 0;
- disp_Q, disp_D, disp_N, done and short = 0;
- change_ready = 1 from the next cycle;
- inventory counters = INV_INIT.
REQ-026 A reset during EJECT SHALL drop disp_* in the next cycle without decrementing any counter; the in-flight request is abandoned with no done pulse.

Configuration
REQ-027 When the macro COIN_INV_EN is defined:
- quarter, dime and nickel inventory counters SHALL decrement on each acknowledged eject of that coin;
- SELECT SHALL skip any coin whose counter is 0 and fall back to the next smaller coin;
- if no usable coin remains while remaining>0, the FSM SHALL go to DONE with short=1.
REQ-028 When COIN_INV_EN is undefined:
- supply is unlimited;
- no counters are built;
- short SHALL be tied to 0.

Structure
REQ-029 The shared package vend_pkg SHALL hold:
- the state enum;
- the coin values VAL_Q=5, VAL_D=2, VAL_N=1;
- the one-hot coin select encoding.
REQ-030 The greedy choice SHALL be implemented in one combinational sub-module, coin_select. Its inputs are remaining and the per-coin availability; its outputs are the one-hot coin and its value.

Verification
REQ-031 Amount 8 (40c), coin_ack given 2 cycles after each disp_* -> the bench SHALL see disp_Q, then disp_D, then disp_N, then done=1 with short=0.
REQ-032 Amount 0 -> the bench SHALL see done in cycle t+1, no disp_* output, and change_ready=1 in cycle t+2.
REQ-033 Amount 15 with coin_ack held permanently high -> the bench SHALL see three quarter ejects, each disp_Q high for exactly one cycle, then done.
REQ-034 Reset asserted while disp_D is high -> the bench SHALL see disp_D low next cycle, no done pulse, and change_ready=1 afterwards.
REQ-035 A change_valid pulse while busy -> the bench SHALL see it ignored, with the remaining sequence unchanged.
REQ-036 With COIN_INV_EN and INV_INIT=1, amount 11 -> the bench SHALL see Q, D, N ejected, then done=1 with short=1 (3 nickels unpaid).
